// File: rtl/axis_packet_arbiter_pkg.sv
// Shared definitions for the AXI4-Stream packet arbiter: FSM state encodings
// and the counter-width helper.
package axis_packet_arbiter_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // Ceiling log2, evaluated at elaboration time for counter sizing.
   function automatic int clogb2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/axis_rr_arb2.sv
// Combinational two-requester round-robin pick: a lone requester wins, and on
// a tie the requester that was not granted last time wins.
module axis_rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       sel_o,
   output logic       any_req_o
);

   assign any_req_o = |req_i;
   assign sel_o     = (&req_i) ? ~last_grant_i : req_i[1];

endmodule

// File: rtl/axis_packet_arbiter.sv
// 2:1 packet-granular round-robin arbiter feeding one AXI4-Stream sink; grant is
// held from first beat to TLAST, and a beat watchdog forces TLAST on long packets.
module axis_packet_arbiter
   import axis_packet_arbiter_pkg::*;
#(
   parameter int C_AXIS_TDATA_WIDTH = 32,
   parameter int C_MAX_BEATS        = 8
) (
   input  logic                            axis_aclk,
   input  logic                            axis_areset,

   input  logic                            s00_axis_tvalid,
   output logic                            s00_axis_tready,
   input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
   input  logic                            s00_axis_tlast,

   input  logic                            s01_axis_tvalid,
   output logic                            s01_axis_tready,
   input  logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
   input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s01_axis_tstrb,
   input  logic                            s01_axis_tlast,

   output logic                            m00_axis_tvalid,
   input  logic                            m00_axis_tready,
   output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                            m00_axis_tlast,

   output logic [1:0]                      grant,
   output logic                            busy,
   output logic [1:0]                      trunc_err
);

   localparam int CNT_W = (clogb2(C_MAX_BEATS) < 1) ? 1 : clogb2(C_MAX_BEATS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_MAX_BEATS - 1);

   logic [0:0]       state_q, state_d;
   logic             sel_q, sel_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [1:0]       trunc_err_q, trunc_err_d;

   logic                            arb_sel, arb_any;
   logic                            src_tvalid, src_tlast;
   logic [C_AXIS_TDATA_WIDTH-1:0]   src_tdata;
   logic [C_AXIS_TDATA_WIDTH/8-1:0] src_tstrb;
   logic                            is_busy, beat;

   axis_rr_arb2 u_arb (
      .req_i        ({s01_axis_tvalid, s00_axis_tvalid}),
      .last_grant_i (last_grant_q),
      .sel_o        (arb_sel),
      .any_req_o    (arb_any)
   );

   assign is_busy    = (state_q == ST_BUSY);
   assign src_tvalid = sel_q ? s01_axis_tvalid : s00_axis_tvalid;
   assign src_tdata  = sel_q ? s01_axis_tdata  : s00_axis_tdata;
   assign src_tstrb  = sel_q ? s01_axis_tstrb  : s00_axis_tstrb;
   assign src_tlast  = sel_q ? s01_axis_tlast  : s00_axis_tlast;

   // Data path is a pure mux of the selected source; everything is forced to zero in IDLE.
   assign m00_axis_tvalid = is_busy & src_tvalid;
   assign m00_axis_tdata  = is_busy ? src_tdata : '0;
   assign m00_axis_tstrb  = is_busy ? src_tstrb : '0;
   assign m00_axis_tlast  = is_busy & (src_tlast | (beat_cnt_q == CNT_MAX));
   assign s00_axis_tready = is_busy & ~sel_q & m00_axis_tready;
   assign s01_axis_tready = is_busy &  sel_q & m00_axis_tready;

   assign beat      = m00_axis_tvalid & m00_axis_tready;
   assign busy      = is_busy;
   assign grant     = is_busy ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
   assign trunc_err = trunc_err_q;

   // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      trunc_err_d  = trunc_err_q;
      if (state_q == ST_IDLE) begin
         if (arb_any) begin
            state_d    = ST_BUSY;
            sel_d      = arb_sel;
            beat_cnt_d = '0;
         end
      end else if (beat) begin
         if (m00_axis_tlast) begin
            state_d      = ST_IDLE;
            last_grant_d = sel_q;
            beat_cnt_d   = '0;
            if (!src_tlast) trunc_err_d[sel_q] = 1'b1;
         end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
         end
      end
   end

   // NOTE: registers use non-blocking assignments so all of them update from pre-edge values.
   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         state_q      <= ST_IDLE;
         sel_q        <= 1'b0;
         last_grant_q <= 1'b1;
         beat_cnt_q   <= '0;
         trunc_err_q  <= 2'b00;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         trunc_err_q  <= trunc_err_d;
      end
   end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter: drivers push expected beats, a
// negedge monitor pops and compares every beat accepted by the sink.
module tb_axis_packet_arbiter;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
      logic [1:0]  grant;
   } beat_t;

   logic        axis_aclk;
   logic        axis_areset;
   logic [1:0]  s_valid, s_ready, s_last;
   logic [31:0] s_data [2];
   logic [3:0]  s_strb [2];
   logic        m_tvalid, m_tready, m_tlast;
   logic [31:0] m_tdata;
   logic [3:0]  m_tstrb;
   logic [1:0]  grant, trunc_err;
   logic        busy;

   beat_t exp_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   logic  prev_last = 1'b0;

   axis_packet_arbiter #(.C_AXIS_TDATA_WIDTH(32), .C_MAX_BEATS(8)) dut (
      .axis_aclk       (axis_aclk),
      .axis_areset     (axis_areset),
      .s00_axis_tvalid (s_valid[0]),
      .s00_axis_tready (s_ready[0]),
      .s00_axis_tdata  (s_data[0]),
      .s00_axis_tstrb  (s_strb[0]),
      .s00_axis_tlast  (s_last[0]),
      .s01_axis_tvalid (s_valid[1]),
      .s01_axis_tready (s_ready[1]),
      .s01_axis_tdata  (s_data[1]),
      .s01_axis_tstrb  (s_strb[1]),
      .s01_axis_tlast  (s_last[1]),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tready (m_tready),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tstrb  (m_tstrb),
      .m00_axis_tlast  (m_tlast),
      .grant           (grant),
      .busy            (busy),
      .trunc_err       (trunc_err)
   );

   initial axis_aclk = 1'b0;
   always #5 axis_aclk = ~axis_aclk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [3:0] strb_of(input logic [31:0] d);
      return d[3:0] ^ 4'hA;
   endfunction

   task automatic push(input logic [31:0] d, input logic last, input logic [1:0] g);
      beat_t e;
      e.data  = d;
      e.strb  = strb_of(d);
      e.last  = last;
      e.grant = g;
      exp_q.push_back(e);
   endtask

   // Sends n beats base, base+1, ... from source src with TLAST on beat last_pos (1-based).
   task automatic send(input int src, input int n, input logic [31:0] base, input int last_pos);
      int waited;
      for (int i = 0; i < n; i++) begin
         s_valid[src] = 1'b1;
         s_data[src]  = base + 32'(i);
         s_strb[src]  = strb_of(base + 32'(i));
         s_last[src]  = (i == last_pos - 1);
         waited = 0;
         do begin
            @(negedge axis_aclk);
            waited++;
         end while (!(s_valid[src] && s_ready[src]) && waited < 300);
         if (waited >= 300) begin
            check("src_handshake_timeout", 64'(waited), 64'(0));
            s_valid[src] = 1'b0;
            return;
         end
         @(posedge axis_aclk);
         #1;
      end
      s_valid[src] = 1'b0;
      s_last[src]  = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge axis_aclk);
      #1 axis_areset = 1'b1;
      repeat (2) @(posedge axis_aclk);
      #1 axis_areset = 1'b0;
   endtask

   // Monitor: every accepted beat is compared with the head of the scoreboard, and
   // the cycle after a last beat must be idle.
   always @(negedge axis_aclk) begin
      if (axis_areset) begin
         prev_last <= 1'b0;
      end else begin
         if (prev_last) check("idle_gap_busy", 64'(busy), 64'(0));
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_tdata);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat", 64'({m_tdata, m_tstrb, m_tlast, grant}), 64'(e));
            end
            prev_last <= m_tlast;
         end else begin
            prev_last <= 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int waited;
      axis_areset = 1'b1;
      s_valid = 2'b00;
      s_last  = 2'b00;
      s_data[0] = '0; s_data[1] = '0;
      s_strb[0] = '0; s_strb[1] = '0;
      m_tready = 1'b1;
      do_reset();

      // Reset state
      @(negedge axis_aclk);
      check("rst_grant", 64'(grant), 64'(2'b00));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_trunc", 64'(trunc_err), 64'(2'b00));
      check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
      check("rst_s_ready", 64'(s_ready), 64'(2'b00));
      @(posedge axis_aclk);
      #1;

      // Test 1: single 8-beat packet from s00
      for (int i = 0; i < 8; i++) push(32'h10 + 32'(i), (i == 7), 2'b01);
      fork
         send(0, 8, 32'h10, 8);
         begin
            @(negedge axis_aclk);
            check("t1_grant_latency", 64'(grant), 64'(2'b00));
            check("t1_no_ready_idle", 64'(s_ready[0]), 64'(0));
            check("t1_idle_tdata", 64'(m_tdata), 64'(0));
            @(negedge axis_aclk);
            check("t1_grant", 64'(grant), 64'(2'b01));
         end
      join
      check("t1_trunc", 64'(trunc_err), 64'(2'b00));

      // Test 2: simultaneous requests alternate, s00 first after reset
      do_reset();
      for (int i = 0; i < 4; i++) push(32'h20 + 32'(i), (i == 3), 2'b01);
      for (int i = 0; i < 4; i++) push(32'h30 + 32'(i), (i == 3), 2'b10);
      fork
         send(0, 4, 32'h20, 4);
         send(1, 4, 32'h30, 4);
      join
      @(posedge axis_aclk);
      #1;
      for (int i = 0; i < 4; i++) push(32'h40 + 32'(i), (i == 3), 2'b01);
      for (int i = 0; i < 4; i++) push(32'h50 + 32'(i), (i == 3), 2'b10);
      fork
         send(0, 4, 32'h40, 4);
         send(1, 4, 32'h50, 4);
      join

      // Test 3: 12-beat packet from s01 is cut at 8, remainder is a second packet
      for (int i = 0; i < 8; i++)  push(32'h100 + 32'(i), (i == 7), 2'b10);
      for (int i = 8; i < 12; i++) push(32'h100 + 32'(i), (i == 11), 2'b10);
      send(1, 12, 32'h100, 12);
      @(negedge axis_aclk);
      check("t3_trunc", 64'(trunc_err), 64'(2'b10));
      @(posedge axis_aclk);
      #1;

      // Test 4: sink stalls every other cycle, s01 waits behind s00
      for (int i = 0; i < 6; i++) push(32'h60 + 32'(i), (i == 5), 2'b01);
      for (int i = 0; i < 3; i++) push(32'h70 + 32'(i), (i == 2), 2'b10);
      fork
         send(0, 6, 32'h60, 6);
         begin
            repeat (2) @(posedge axis_aclk);
            #1;
            send(1, 3, 32'h70, 3);
         end
         begin
            repeat (12) begin
               @(posedge axis_aclk);
               #1 m_tready = ~m_tready;
            end
            m_tready = 1'b1;
         end
         begin
            repeat (20) begin
               @(negedge axis_aclk);
               if (grant == 2'b01) check("t4_s01_blocked", 64'(s_ready[1]), 64'(0));
            end
         end
      join
      m_tready = 1'b1;
      @(negedge axis_aclk);
      check("t4_trunc_sticky", 64'(trunc_err), 64'(2'b10));
      @(posedge axis_aclk);
      #1;

      // Test 5: reset on beat 3 of an s00 packet abandons it
      push(32'h80, 1'b0, 2'b01);
      push(32'h81, 1'b0, 2'b01);
      s_valid[0] = 1'b1;
      s_last[0]  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_data[0] = 32'h80 + 32'(i);
         s_strb[0] = strb_of(32'h80 + 32'(i));
         waited = 0;
         do begin
            @(negedge axis_aclk);
            waited++;
         end while (!s_ready[0] && waited < 20);
         if (waited >= 20) check("t5_handshake_timeout", 64'(waited), 64'(0));
         @(posedge axis_aclk);
         #1;
      end
      s_data[0] = 32'h82;
      s_strb[0] = strb_of(32'h82);
      axis_areset = 1'b1;
      @(posedge axis_aclk);
      #1;
      axis_areset = 1'b0;
      s_valid[0]  = 1'b0;
      @(negedge axis_aclk);
      check("t5_m_tvalid", 64'(m_tvalid), 64'(0));
      check("t5_m_tdata", 64'(m_tdata), 64'(0));
      check("t5_m_tlast", 64'(m_tlast), 64'(0));
      check("t5_grant", 64'(grant), 64'(2'b00));
      check("t5_busy", 64'(busy), 64'(0));
      check("t5_trunc", 64'(trunc_err), 64'(2'b00));
      check("t5_s_ready", 64'(s_ready), 64'(2'b00));
      @(posedge axis_aclk);
      #1;
      for (int i = 0; i < 2; i++) push(32'h90 + 32'(i), (i == 1), 2'b01);
      for (int i = 0; i < 2; i++) push(32'hA0 + 32'(i), (i == 1), 2'b10);
      fork
         send(0, 2, 32'h90, 2);
         send(1, 2, 32'hA0, 2);
      join

      repeat (4) @(negedge axis_aclk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
